// File: rtl/param_sram_ctrl_pkg.sv
// param_sram_ctrl_pkg: shared types and constants for the parameter SRAM controller
package param_sram_ctrl_pkg;
    typedef enum logic {IDLE, BURST} state_e;
    localparam int RSP_DEPTH = 2;
    localparam int CMD_ADDR_W = 2;
    localparam int CMD_DATA_W = 32;
    localparam int CMD_LEN_W = 4;
    typedef struct packed {
        logic                  write;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] wdata;
        logic [CMD_LEN_W-1:0]  len;
    } sram_cmd_t;
endpackage

// File: rtl/sram_rsp_fifo.sv
// sram_rsp_fifo: 2-entry read-response FIFO; head entry always visible on rdata
module sram_rsp_fifo
    import param_sram_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        count,
    output logic              empty
);
    logic [DATA_W-1:0] mem [RSP_DEPTH];
    logic              wp, rp;
    assign rdata = mem[rp];
    assign empty = count == 2'd0;
    // storage, pointers and occupancy; push and pop together leave count unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem   <= '{default: '0};
            wp    <= 1'b0;
            rp    <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                mem[wp] <= wdata;
                wp      <= !wp;
            end
            if (pop) rp <= !rp;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/param_sram_ctrl.sv
// param_sram_ctrl: valid/ready front end for a single-port param SRAM (bursts with SRAM_CTRL_BURST_EN)
module param_sram_ctrl
    import param_sram_ctrl_pkg::*;
#(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [LEN_W-1:0]  req_len,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              mem_cs,
    output logic              mem_oe,
    output logic              mem_W_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_W_data,
    input  logic [DATA_W-1:0] mem_R_data
);
    logic       up, rd_inflight, pop, credit_ok, in_burst, accept, issue, empty;
    logic [1:0] count;
`ifdef SRAM_CTRL_BURST_EN
    state_e            state;
    logic [ADDR_W-1:0] b_addr;
    logic [LEN_W-1:0]  b_rem;
    assign in_burst = state == BURST;
`else
    logic unused_len;
    assign unused_len = ^req_len;
    assign in_burst   = 1'b0;
`endif
    assign pop        = rsp_valid && rsp_ready;
    assign credit_ok  = ({1'b0, count} + {2'b0, rd_inflight} - {2'b0, pop}) < 3'd2;
    assign req_ready  = up && !in_burst && (req_write || credit_ok);
    assign accept     = req_valid && req_ready;
    assign issue      = accept || (in_burst && credit_ok);
    assign mem_cs     = issue;
    assign mem_W_req  = !(accept && req_write);
`ifdef SRAM_CTRL_BURST_EN
    assign mem_addr   = !issue ? '0 : in_burst ? b_addr : req_addr;
`else
    assign mem_addr   = issue ? req_addr : '0;
`endif
    assign mem_W_data = accept ? req_wdata : '0;
    assign mem_oe     = rd_inflight;
    assign rsp_valid  = !empty;
    // ready comes up one cycle after reset release; track the read whose data returns next cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up          <= 1'b0;
            rd_inflight <= 1'b0;
        end else begin
            up          <= 1'b1;
            rd_inflight <= issue && mem_W_req;
        end
    end
`ifdef SRAM_CTRL_BURST_EN
    // burst sequencer: the accept cycle issues the first word, BURST issues the remaining b_rem words
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            b_addr <= '0;
            b_rem  <= '0;
        end else if (state == IDLE) begin
            if (accept && !req_write && req_len != '0) begin
                state  <= BURST;
                b_addr <= req_addr + 1'b1;
                b_rem  <= req_len;
            end
        end else if (credit_ok) begin
            b_addr <= b_addr + 1'b1;
            b_rem  <= b_rem - 1'b1;
            if (b_rem == LEN_W'(1)) state <= IDLE;
        end
    end
`endif
    sram_rsp_fifo #(.DATA_W(DATA_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rd_inflight),
        .wdata (mem_R_data),
        .pop   (pop),
        .rdata (rsp_data),
        .count (count),
        .empty (empty)
    );
endmodule

// File: tb/tb_param_sram_ctrl.sv
// tb_param_sram_ctrl: directed checks of param_sram_ctrl against a small registered-read SRAM model
module tb_param_sram_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
    logic [1:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_len = '0;
    logic        req_ready, rsp_valid, mem_cs, mem_oe, mem_W_req;
    logic [31:0] rsp_data, mem_W_data, mem_R_data;
    logic [1:0]  mem_addr;
    logic [31:0] sram [4];
    logic        init_done = 1'b0;
    int          total = 0, bad = 0;

    param_sram_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_W_req(mem_W_req), .mem_addr(mem_addr),
        .mem_W_data(mem_W_data), .mem_R_data(mem_R_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 4; i++) sram[i] <= 32'h1000 + i;
        end else if (mem_cs && !mem_W_req) begin
            sram[mem_addr] <= mem_W_data;
        end else if (mem_cs) begin
            mem_R_data <= sram[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = a;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_write = 1'b0;
    endtask

    initial begin
        logic [31:0] exp2 [4];
        exp2 = '{32'h1000, 32'hDEADBEEF, 32'h1002, 32'h1003};
        cyc();
        cyc();
        init_done = 1'b1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_mem_cs", mem_cs, 0);
        chk("rst_mem_oe", mem_oe, 0);
        chk("rst_mem_W_req", mem_W_req, 1);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_W_data", mem_W_data, 0);
        rst_n = 1'b1;
        #1;
        chk("release_ready_low", req_ready, 0);
        cyc();
        chk("ready_after_release", req_ready, 1);

        // 1: write then read of address 1
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 2'd1; req_wdata = 32'hDEADBEEF;
        #1;
        chk("t1_wr_ready", req_ready, 1);
        chk("t1_wr_cs", mem_cs, 1);
        chk("t1_wr_W_req", mem_W_req, 0);
        chk("t1_wr_addr", mem_addr, 1);
        chk("t1_wr_data", mem_W_data, 32'hDEADBEEF);
        cyc();
        rd(2'd1);
        #1;
        chk("t1_rd_cs", mem_cs, 1);
        chk("t1_rd_W_req", mem_W_req, 1);
        chk("t1_rd_oe_low", mem_oe, 0);
        cyc();
        idle();
        #1;
        chk("t1_oe_capture", mem_oe, 1);
        chk("t1_cs_idle", mem_cs, 0);
        chk("t1_no_early_rsp", rsp_valid, 0);
        cyc();
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_rsp_data", rsp_data, 32'hDEADBEEF);
        chk("t1_oe_off", mem_oe, 0);
        cyc();
        chk("t1_drained", rsp_valid, 0);

        // 2: back-to-back reads of 0..3
        for (int i = 0; i < 6; i++) begin
            if (i < 4) rd(2'(i)); else idle();
            #1;
            if (i < 4) chk("t2_ready", req_ready, 1);
            if (i >= 2) begin
                chk("t2_rsp_valid", rsp_valid, 1);
                chk("t2_rsp_data", rsp_data, exp2[i-2]);
            end
            cyc();
        end
        chk("t2_drained", rsp_valid, 0);

        // 3: consumer stalled, third read waits for credit
        rsp_ready = 1'b0;
        rd(2'd0);
        #1;
        chk("t3_rd0_ready", req_ready, 1);
        cyc();
        rd(2'd2);
        #1;
        chk("t3_rd2_ready", req_ready, 1);
        cyc();
        rd(2'd3);
        #1;
        chk("t3_stall_a", req_ready, 0);
        chk("t3_stall_cs", mem_cs, 0);
        cyc();
        chk("t3_stall_b", req_ready, 0);
        chk("t3_head_valid", rsp_valid, 1);
        chk("t3_head_data", rsp_data, 32'h1000);
        cyc();
        rsp_ready = 1'b1;
        #1;
        chk("t3_credit_back", req_ready, 1);
        chk("t3_pop_data", rsp_data, 32'h1000);
        cyc();
        idle();
        #1;
        chk("t3_second", rsp_data, 32'h1002);
        cyc();
        chk("t3_third_valid", rsp_valid, 1);
        chk("t3_third", rsp_data, 32'h1003);
        cyc();
        chk("t3_drained", rsp_valid, 0);

`ifdef SRAM_CTRL_BURST_EN
        // 4: burst of 4 from address 2 wraps to 0,1
        rd(2'd2);
        req_len = 4'd3;
        #1;
        chk("t4_ready", req_ready, 1);
        chk("t4_addr0", mem_addr, 2);
        cyc();
        idle();
        req_len = 4'd0;
        #1;
        chk("t4_busy", req_ready, 0);
        chk("t4_cs1", mem_cs, 1);
        chk("t4_addr1", mem_addr, 3);
        cyc();
        chk("t4_addr2", mem_addr, 0);
        chk("t4_busy2", req_ready, 0);
        chk("t4_rsp0", rsp_data, 32'h1002);
        cyc();
        chk("t4_addr3", mem_addr, 1);
        chk("t4_rsp1", rsp_data, 32'h1003);
        cyc();
        chk("t4_done_cs", mem_cs, 0);
        chk("t4_ready_back", req_ready, 1);
        chk("t4_rsp2", rsp_data, 32'h1000);
        cyc();
        chk("t4_rsp3_valid", rsp_valid, 1);
        chk("t4_rsp3", rsp_data, 32'hDEADBEEF);
        cyc();
        chk("t4_drained", rsp_valid, 0);
`endif

        // 6: write@0 then read@0 while a prior response pops as the new one pushes
        rd(2'd2);
        #1;
        cyc();
        req_valid = 1'b1; req_write = 1'b1; req_addr = 2'd0; req_wdata = 32'hCAFE0000;
        #1;
        chk("t6_oe_prior", mem_oe, 1);
        cyc();
        rsp_ready = 1'b0;
        rd(2'd0);
        #1;
        chk("t6_rd_ready", req_ready, 1);
        chk("t6_oe_wr", mem_oe, 0);
        cyc();
        idle();
        rsp_ready = 1'b1;
        #1;
        chk("t6_oe_capture", mem_oe, 1);
        chk("t6_prior_data", rsp_data, 32'h1002);
        cyc();
        chk("t6_new_valid", rsp_valid, 1);
        chk("t6_new_data", rsp_data, 32'hCAFE0000);
        chk("t6_oe_off", mem_oe, 0);
        cyc();
        chk("t6_count_stable", rsp_valid, 0);

        // 5: reset with traffic in flight
        rsp_ready = 1'b0;
        rd(2'd1);
        cyc();
        rst_n = 1'b0;
        #1;
        chk("t5_ready", req_ready, 0);
        chk("t5_cs", mem_cs, 0);
        chk("t5_oe", mem_oe, 0);
        chk("t5_W_req", mem_W_req, 1);
        chk("t5_rsp_valid", rsp_valid, 0);
        chk("t5_rsp_data", rsp_data, 0);
        cyc();
        idle();
        rst_n = 1'b1;
        #1;
        chk("t5_release_ready", req_ready, 0);
        cyc();
        chk("t5_no_stale", rsp_valid, 0);
        chk("t5_ready_up", req_ready, 1);
        cyc();
        chk("t5_no_stale2", rsp_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
